and_gate_unit: RTL and testbench

- Registered, parameterizable bitwise AND stage with a valid/ready handshake on input and output.
- Computes out = a & b per lane.
- Also provides status flags: all-ones, zero, and a population count of the result.
- Used as a leaf datapath stage wherever a gated mask is needed; the skid buffer gives full throughput under backpressure.

---
 rtl/and_gate_pkg.sv | 18 +
 rtl/popcount_tree.sv | 43 ++++
 rtl/and_gate_unit.sv | 107 ++++++++++
 tb/tb_and_gate_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_pkg
//  Description : Shared constants and helpers for the gated-mask AND stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package and_gate_pkg;

  // Widest lane count the stage is qualified for.
  localparam int MAX_WIDTH = 64;

  // Bits needed to hold a population count of 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_tree.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_tree
//  Description : Combinational pairwise adder tree counting set bits of a
//                vector. Leaves are padded to a power of two with zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_tree
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  localparam int c_levels = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int c_leaves = 1 << c_levels;

  // Level 0 holds one-bit leaves; each higher level halves the node count.
  for (genvar l = 0; l <= c_levels; l++) begin : g_level
    logic [CNT_W-1:0] sum [0:(c_leaves >> l)-1];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < c_leaves; i++) begin : g_bit
        if (i < WIDTH) begin : g_real
          assign sum[i] = CNT_W'(bits[i]);
        end else begin : g_pad
          assign sum[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < (c_leaves >> l); i++) begin : g_pair
        assign sum[i] = g_level[l-1].sum[2*i] + g_level[l-1].sum[2*i+1];
      end
    end
  end

  assign count = g_level[c_levels].sum[0];

endmodule
`default_nettype wire

// File: rtl/and_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_unit
//  Description : Registered bitwise AND stage with valid/ready on both sides,
//                a one-entry skid buffer for full throughput under
//                backpressure, and registered all-ones / zero / popcount flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_gate_unit
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_all,
  output logic             out_zero,
  output logic [CNT_W-1:0] ones_cnt
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("and_gate_unit: WIDTH must be within 1..%0d", MAX_WIDTH);
  end

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_in_xfer;
  logic             w_out_free;
  logic             w_load;

  logic [WIDTH-1:0] r_skid;
  logic             r_skid_full;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_all;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;

  // Ready is gated by reset so nothing is accepted in a reset cycle.
  assign in_ready   = rst_n & ~r_skid_full;
  assign w_in_xfer  = in_valid & in_ready;
  // Output register can take a new value if empty or being drained now.
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_and      = a & b;
  // The skid entry is always older than the incoming pair, so it goes first.
  assign w_next     = r_skid_full ? r_skid : w_and;
  assign w_load     = w_out_free & (r_skid_full | w_in_xfer);

  popcount_tree #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcount (
    .bits  (w_next),
    .count (w_cnt)
  );

  // Output register: result and flags load together from the selected source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_all       <= 1'b0;
      r_zero      <= 1'b1;
      r_cnt       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out       <= w_next;
      r_all       <= &w_next;
      r_zero      <= ~|w_next;
      r_cnt       <= w_cnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Skid entry: park an accepted pair while the output register is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_full <= 1'b0;
      r_skid      <= '0;
    end else if (r_skid_full) begin
      if (w_out_free) begin
        r_skid_full <= 1'b0;
      end
    end else if (w_in_xfer && !w_out_free) begin
      r_skid_full <= 1'b1;
      r_skid      <= w_and;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_all   = r_all;
  assign out_zero  = r_zero;
  assign ones_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_and_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and_gate_unit
//  Description : Self-checking bench for and_gate_unit at WIDTH=1 and WIDTH=8.
//                The WIDTH=8 instance is tracked by a queue model of items in
//                flight; directed steps add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v8, rdy8, ov8, ordy8, all8, zero8;
  logic [7:0] a8, b8, o8;
  logic [3:0] cnt8;

  logic       v1, rdy1, ov1, ordy1, all1, zero1, a1, b1, o1;
  logic [0:0] cnt1;

  integer total = 0;
  integer bad   = 0;

  and_gate_unit #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out(o8), .out_all(all8),
    .out_zero(zero8), .ones_cnt(cnt8)
  );

  and_gate_unit #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy1), .out(o1), .out_all(all1),
    .out_zero(zero1), .ones_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the WIDTH=8 stage: an ordered queue holding at most two pending
  // results, plus the value the output register is currently showing.
  logic [7:0] q[$];
  logic [7:0] shown = 8'h00;
  bit         model_on = 1'b0;

  // Compare on each falling edge, then advance the model with the inputs
  // that the next rising edge will sample.
  always @(negedge clk) begin
    bit give, take;
    if (model_on) begin
      chk("m_valid", ov8, q.size() > 0);
      chk("m_ready", rdy8, rst_n && (q.size() < 2));
      chk("m_out", o8, shown);
      chk("m_cnt", cnt8, $countones(shown));
      chk("m_all", all8, shown == 8'hFF);
      chk("m_zero", zero8, shown == 8'h00);
    end
    if (!rst_n) begin
      q.delete();
      shown    = 8'h00;
      model_on = 1'b1;
    end else if (model_on) begin
      give = (q.size() > 0) && ordy8;
      take = v8 && (q.size() < 2);
      if (give) void'(q.pop_front());
      if (take) q.push_back(a8 & b8);
      if (q.size() > 0) shown = q[0];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v8 = 1'b0; a8 = 'x; b8 = 'x; ordy8 = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ordy1 = 1'b1;
    repeat (3) tick();

    chk("rst_valid", ov8, 0);
    chk("rst_out", o8, 0);
    chk("rst_zero", zero8, 1);
    chk("rst_all", all8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_ready", rdy8, 0);
    chk("rst1_zero", zero1, 1);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", rdy8, 1);

    // WIDTH=1 truth table, one pair per cycle
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; a1 = i[1]; b1 = i[0];
      tick();
      chk("w1_valid", ov1, 1);
      chk("w1_out", o1, i == 3);
      chk("w1_all", all1, i == 3);
      chk("w1_cnt", cnt1, i == 3);
      chk("w1_zero", zero1, i != 3);
    end
    v1 = 1'b0;
    tick();
    chk("w1_idle_valid", ov1, 0);
    chk("w1_idle_hold", o1, 1);

    // WIDTH=8 basic patterns
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    chk("p1_out", o8, 8'h30);
    chk("p1_cnt", cnt8, 2);
    chk("p1_all", all8, 0);
    chk("p1_zero", zero8, 0);
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    chk("p2_out", o8, 8'hFF);
    chk("p2_all", all8, 1);
    chk("p2_cnt", cnt8, 8);
    v8 = 1'b0; a8 = 'x; b8 = 'x;
    tick();
    chk("p3_valid", ov8, 0);
    chk("p3_hold", o8, 8'hFF);

    // Backpressure: fill output register and skid, then drain
    ordy8 = 1'b0; v8 = 1'b1; a8 = 8'h0F; b8 = 8'hFF;
    tick();
    chk("bp_first", o8, 8'h0F);
    chk("bp_ready1", rdy8, 1);
    a8 = 8'hAA; b8 = 8'h0F;
    tick();
    chk("bp_ready0", rdy8, 0);
    chk("bp_hold", o8, 8'h0F);
    a8 = 8'h55; b8 = 8'h55;
    tick();
    chk("bp_blocked_ready", rdy8, 0);
    chk("bp_blocked_out", o8, 8'h0F);
    chk("bp_blocked_valid", ov8, 1);
    v8 = 1'b0; a8 = 'x; b8 = 'x; ordy8 = 1'b1;
    tick();
    chk("bp_drain_out", o8, 8'h0A);
    chk("bp_drain_valid", ov8, 1);
    chk("bp_drain_ready", rdy8, 1);
    tick();
    chk("bp_empty", ov8, 0);
    chk("bp_empty_hold", o8, 8'h0A);

    // Back-to-back transfers at full rate
    for (int i = 0; i < 16; i++) begin
      v8 = 1'b1; a8 = 8'(i * 17); b8 = 8'hF3 ^ 8'(i);
      tick();
      chk("b2b_ready", rdy8, 1);
      chk("b2b_valid", ov8, 1);
      chk("b2b_out", o8, a8 & b8);
    end
    v8 = 1'b0; a8 = 'x; b8 = 'x;
    tick();

    // Reset while skid is full
    ordy8 = 1'b0; v8 = 1'b1; a8 = 8'hC3; b8 = 8'hFF;
    tick();
    a8 = 8'h3C;
    tick();
    chk("mr_full", rdy8, 0);
    v8 = 1'b0; a8 = 'x; b8 = 'x; rst_n = 1'b0;
    tick();
    chk("mr_valid", ov8, 0);
    chk("mr_out", o8, 0);
    chk("mr_zero", zero8, 1);
    chk("mr_cnt", cnt8, 0);
    chk("mr_ready", rdy8, 0);
    rst_n = 1'b1; ordy8 = 1'b1;
    #1;
    chk("mr_ready_after", rdy8, 1);
    tick();
    chk("mr_no_stale1", ov8, 0);
    chk("mr_out_after", o8, 0);
    tick();
    chk("mr_no_stale2", ov8, 0);

    // Random traffic with occasional resets; the model checks every cycle
    for (int n = 0; n < 10000; n++) begin
      v8    = 1'($urandom_range(0, 1));
      ordy8 = 1'($urandom_range(0, 1));
      if (v8) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end else begin
        a8 = 'x;
        b8 = 'x;
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1; v8 = 1'b0; a8 = 'x; b8 = 'x; ordy8 = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
